// File: rtl/nio2_sys_timer_host.sv
`default_nettype none
// ============================================================================
// nio2_sys_timer_host : Avalon-MM host that programs and services the interval
// timer; counter snapshots are built only with TIMER_HOST_SNAPSHOT_EN.
// Revision 1.0
// ============================================================================
module nio2_sys_timer_host #(
   parameter int CONTINUOUS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic [31:0] cfg_period,
   input  logic        snap_req,
   output logic [2:0]  tmr_address,
   output logic        tmr_chipselect,
   output logic        tmr_write_n,
   output logic [15:0] tmr_writedata,
   input  logic [15:0] tmr_readdata,
   input  logic        tmr_irq,
   output logic        busy,
   output logic [31:0] tick_count,
   output logic        tick_pulse,
   output logic        cfg_err,
   output logic        fault,
   output logic [31:0] snap_value,
   output logic        snap_valid
);

   localparam logic [2:0]  REG_STATUS  = 3'd0;
   localparam logic [2:0]  REG_CONTROL = 3'd1;
   localparam logic [2:0]  REG_PERIODL = 3'd2;
   localparam logic [2:0]  REG_PERIODH = 3'd3;
`ifdef TIMER_HOST_SNAPSHOT_EN
   localparam logic [2:0]  REG_SNAPL   = 3'd4;
   localparam logic [2:0]  REG_SNAPH   = 3'd5;
`endif
   localparam logic [15:0] CTRL_START  = (CONTINUOUS != 0) ? 16'h0007 : 16'h0005;
   localparam logic [15:0] CTRL_STOP   = 16'h0008;

   typedef enum logic [3:0] {
      IDLE, WR_PERL, WR_PERH, WR_CTRL, RUN, CLR_ST, RD_ST, RD_ST_W, WR_STOP
`ifdef TIMER_HOST_SNAPSHOT_EN
      , SNAP_WR, SNAP_L, SNAP_L_W, SNAP_H, SNAP_H_W
`endif
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] period_q;
   logic        stop_pend;
   logic        start_ok;

   assign start_ok   = (state == IDLE) && cfg_start && (cfg_period != 32'd0);
   assign busy       = (state != IDLE);
   assign tick_pulse = (state == RD_ST_W);

`ifdef TIMER_HOST_SNAPSHOT_EN
   logic        snap_pend;
   logic [15:0] snap_lo;
   logic [31:0] snap_hold;
   logic        unused_rd;

   assign unused_rd = ^{tmr_readdata[15:2], tmr_readdata[0]};
`else
   logic        unused_in;

   assign unused_in = ^{snap_req, tmr_readdata[15:2], tmr_readdata[0]};
`endif

   always_comb begin
      state_next     = state;
      tmr_address    = REG_STATUS;
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_writedata  = 16'h0000;
      case (state)
         IDLE: begin
            if (start_ok) state_next = WR_PERL;
         end
         WR_PERL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_PERIODL;
            tmr_writedata  = period_q[15:0];
            state_next     = WR_PERH;
         end
         WR_PERH: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_PERIODH;
            tmr_writedata  = period_q[31:16];
            state_next     = WR_CTRL;
         end
         WR_CTRL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_CONTROL;
            tmr_writedata  = CTRL_START;
            state_next     = RUN;
         end
         RUN: begin
            if (stop_pend)      state_next = WR_STOP;
            else if (tmr_irq)   state_next = CLR_ST;
`ifdef TIMER_HOST_SNAPSHOT_EN
            else if (snap_pend) state_next = SNAP_WR;
`endif
         end
         CLR_ST: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_STATUS;
            state_next     = RD_ST;
         end
         RD_ST: begin
            tmr_chipselect = 1'b1;
            tmr_address    = REG_STATUS;
            state_next     = RD_ST_W;
         end
         RD_ST_W: begin
            // A one-shot timer is expected to have stopped; only continuous mode checks RUN.
            if (CONTINUOUS == 0 || !tmr_readdata[1]) state_next = IDLE;
            else                                     state_next = RUN;
         end
         WR_STOP: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_CONTROL;
            tmr_writedata  = CTRL_STOP;
            state_next     = IDLE;
         end
`ifdef TIMER_HOST_SNAPSHOT_EN
         SNAP_WR: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = REG_SNAPL;
            state_next     = SNAP_L;
         end
         SNAP_L: begin
            tmr_chipselect = 1'b1;
            tmr_address    = REG_SNAPL;
            state_next     = SNAP_L_W;
         end
         SNAP_L_W: state_next = SNAP_H;
         SNAP_H: begin
            tmr_chipselect = 1'b1;
            tmr_address    = REG_SNAPH;
            state_next     = SNAP_H_W;
         end
         SNAP_H_W: state_next = RUN;
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         period_q   <= 32'd0;
         stop_pend  <= 1'b0;
         tick_count <= 32'd0;
         cfg_err    <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state   <= state_next;
         cfg_err <= (state == IDLE) && cfg_start && (cfg_period == 32'd0);
         if (start_ok) begin
            period_q <= cfg_period;
            fault    <= 1'b0;
         end
         if (state == RD_ST_W) begin
            tick_count <= tick_count + 32'd1;
            if (CONTINUOUS != 0 && !tmr_readdata[1]) fault <= 1'b1;
         end
         // Dropping the flag on any return to IDLE keeps a stale stop from killing the next start.
         if (state_next == WR_STOP || state_next == IDLE) stop_pend <= 1'b0;
         else if (cfg_stop && state != IDLE)              stop_pend <= 1'b1;
      end
   end

`ifdef TIMER_HOST_SNAPSHOT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_pend <= 1'b0;
         snap_lo   <= 16'h0000;
         snap_hold <= 32'd0;
      end else begin
         if (state_next == SNAP_WR || state_next == IDLE) snap_pend <= 1'b0;
         else if (snap_req && state != IDLE)              snap_pend <= 1'b1;
         if (state == SNAP_L_W) snap_lo <= tmr_readdata;
         if (state == SNAP_H_W) snap_hold <= {tmr_readdata, snap_lo};
      end
   end

   // The new value is forwarded in the capture cycle so it lines up with snap_valid.
   assign snap_value = (state == SNAP_H_W) ? {tmr_readdata, snap_lo} : snap_hold;
   assign snap_valid = (state == SNAP_H_W);
`else
   assign snap_value = 32'd0;
   assign snap_valid = 1'b0;
`endif

endmodule
`default_nettype wire
